// File: rtl/score_pkg.sv
// score_pkg: shared constants, state encoding and helpers for the leaderboard
// controller (score_rank_ctrl) and its storage (score_table).
package score_pkg;

  localparam int SCORE_W    = 10;
  localparam int USERS      = 8;
  localparam int SONGS      = 3;
  localparam int USER_W     = $clog2(USERS);
  localparam int RANK_W     = $clog2(USERS);
  localparam int SONG_IDX_W = $clog2(SONGS);

  localparam logic [SONGS-1:0] SONG_LITTLESTAR     = 3'b001;
  localparam logic [SONGS-1:0] SONG_JILEJINGTU     = 3'b010;
  localparam logic [SONGS-1:0] SONG_CHUNXIAQIUDONG = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when exactly one bit of the song select is set.
  function automatic logic is_onehot(input logic [SONGS-1:0] sel);
    return (sel != {SONGS{1'b0}}) && ((sel & (sel - SONGS'(1))) == {SONGS{1'b0}});
  endfunction

  // Row index of a one-hot song select; non-one-hot values map to row 0 and
  // must be filtered with is_onehot by the caller.
  function automatic logic [SONG_IDX_W-1:0] song_idx(input logic [SONGS-1:0] sel);
    logic [SONG_IDX_W-1:0] idx;
    case (sel)
      SONG_LITTLESTAR:     idx = 2'd0;
      SONG_JILEJINGTU:     idx = 2'd1;
      SONG_CHUNXIAQIUDONG: idx = 2'd2;
      default:             idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/score_table.sv
// score_table: SONGS x USERS array of SCORE_W-bit scores.
//   clk, rst               clock, async active-high reset (clears the table)
//   wr_en/wr_song/wr_user/wr_score   write port (song as row index)
//   rd_song/rd_user -> rd_score      scan read port
//   tg_song/tg_user -> tg_score      target lookup port for query acceptance
//   scores_song0/1/2       flattened rows, user u at [u*SCORE_W +: SCORE_W]
// Build option: SCORE_KEEP_BEST_EN -- when defined, a write only lands if the
// new score is strictly greater than the stored one (personal best).
module score_table
  import score_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [SONG_IDX_W-1:0]       wr_song,
  input  logic [USER_W-1:0]           wr_user,
  input  logic [SCORE_W-1:0]          wr_score,
  input  logic [SONG_IDX_W-1:0]       rd_song,
  input  logic [USER_W-1:0]           rd_user,
  output logic [SCORE_W-1:0]          rd_score,
  input  logic [SONG_IDX_W-1:0]       tg_song,
  input  logic [USER_W-1:0]           tg_user,
  output logic [SCORE_W-1:0]          tg_score,
  output logic [USERS*SCORE_W-1:0]    scores_song0,
  output logic [USERS*SCORE_W-1:0]    scores_song1,
  output logic [USERS*SCORE_W-1:0]    scores_song2
);

  logic [SCORE_W-1:0] mem_r [SONGS][USERS];
  logic               wr_do_s;

`ifdef SCORE_KEEP_BEST_EN
  assign wr_do_s = wr_en && (wr_score > mem_r[wr_song][wr_user]);
`else
  assign wr_do_s = wr_en;
`endif

  // Score storage: cleared on reset, single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SONGS; s++) begin
        for (int u = 0; u < USERS; u++) begin
          mem_r[s][u] <= {SCORE_W{1'b0}};
        end
      end
    end else if (wr_do_s) begin
      mem_r[wr_song][wr_user] <= wr_score;
    end
  end

  assign rd_score = mem_r[rd_song][rd_user];
  assign tg_score = mem_r[tg_song][tg_user];

  for (genvar u = 0; u < USERS; u++) begin : g_flat
    assign scores_song0[u*SCORE_W +: SCORE_W] = mem_r[0][u];
    assign scores_song1[u*SCORE_W +: SCORE_W] = mem_r[1][u];
    assign scores_song2[u*SCORE_W +: SCORE_W] = mem_r[2][u];
  end

endmodule

// File: rtl/score_rank_ctrl.sv
// score_rank_ctrl: per-song leaderboard owner. Arbitrates score updates
// (fixed priority) against rank queries and computes a user's rank with a
// serial USERS-step scan over a frozen table.
//   clk, rst                     clock, async active-high reset
//   upd_valid/upd_ready          update handshake; upd_song one-hot,
//   upd_user, upd_score          slot and new score
//   q_req/q_ready                query handshake; q_song one-hot, q_user
//   q_done                       one-cycle pulse, results valid from then on
//   q_bad                        last completed query had a bad song select
//   rank, user_score, best_score held query results
//   scores_song0/1/2             flattened score rows
// Build option: SCORE_KEEP_BEST_EN (see score_table) keeps personal bests.
module score_rank_ctrl
  import score_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [SONGS-1:0]         upd_song,
  input  logic [USER_W-1:0]        upd_user,
  input  logic [SCORE_W-1:0]       upd_score,
  input  logic                     q_req,
  output logic                     q_ready,
  input  logic [SONGS-1:0]         q_song,
  input  logic [USER_W-1:0]        q_user,
  output logic                     q_done,
  output logic                     q_bad,
  output logic [RANK_W-1:0]        rank,
  output logic [SCORE_W-1:0]       user_score,
  output logic [SCORE_W-1:0]       best_score,
  output logic [USERS*SCORE_W-1:0] scores_song0,
  output logic [USERS*SCORE_W-1:0] scores_song1,
  output logic [USERS*SCORE_W-1:0] scores_song2
);

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    upd_ready_s;
  logic                    q_ready_s;
  logic                    upd_acc_s;
  logic                    q_acc_s;
  logic                    q_ok_s;

  logic [SONG_IDX_W-1:0]   song_idx_r;
  logic [USER_W-1:0]       k_r;
  logic [RANK_W-1:0]       cnt_r;
  logic [SCORE_W-1:0]      max_r;
  logic [SCORE_W-1:0]      target_r;

  logic [SCORE_W-1:0]      scan_entry_s;
  logic [SCORE_W-1:0]      tg_score_s;
  logic                    gt_s;
  logic                    scan_last_s;
  logic [RANK_W-1:0]       cnt_next_s;
  logic [SCORE_W-1:0]      max_next_s;

  logic                    q_done_r;
  logic                    q_bad_r;
  logic [RANK_W-1:0]       rank_r;
  logic [SCORE_W-1:0]      user_score_r;
  logic [SCORE_W-1:0]      best_r;

  assign q_ok_s = is_onehot(q_song);

  score_table u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (upd_acc_s && is_onehot(upd_song)),
    .wr_song      (song_idx(upd_song)),
    .wr_user      (upd_user),
    .wr_score     (upd_score),
    .rd_song      (song_idx_r),
    .rd_user      (k_r),
    .rd_score     (scan_entry_s),
    .tg_song      (song_idx(q_song)),
    .tg_user      (q_user),
    .tg_score     (tg_score_s),
    .scores_song0 (scores_song0),
    .scores_song1 (scores_song1),
    .scores_song2 (scores_song2)
  );

  // Scan step: the target never beats itself, so cnt cannot pass USERS-1.
  assign gt_s        = scan_entry_s > target_r;
  assign cnt_next_s  = cnt_r + {{(RANK_W-1){1'b0}}, gt_s};
  assign max_next_s  = (scan_entry_s > max_r) ? scan_entry_s : max_r;
  assign scan_last_s = (k_r == USER_W'(USERS-1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and handshakes; an update blocks a query in the same cycle.
  always_comb begin
    state_next_s = state_r;
    upd_ready_s  = 1'b0;
    q_ready_s    = 1'b0;
    upd_acc_s    = 1'b0;
    q_acc_s      = 1'b0;
    case (state_r)
      IDLE: begin
        upd_ready_s = 1'b1;
        q_ready_s   = ~upd_valid;
        upd_acc_s   = upd_valid;
        q_acc_s     = q_req && ~upd_valid;
        if (q_acc_s) begin
          state_next_s = q_ok_s ? SCAN : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (scan_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SCAN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Scan datapath and registered query results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      song_idx_r   <= {SONG_IDX_W{1'b0}};
      k_r          <= {USER_W{1'b0}};
      cnt_r        <= {RANK_W{1'b0}};
      max_r        <= {SCORE_W{1'b0}};
      target_r     <= {SCORE_W{1'b0}};
      q_done_r     <= 1'b0;
      q_bad_r      <= 1'b0;
      rank_r       <= {RANK_W{1'b0}};
      user_score_r <= {SCORE_W{1'b0}};
      best_r       <= {SCORE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          q_done_r <= 1'b0;
          if (q_acc_s) begin
            song_idx_r <= song_idx(q_song);
            target_r   <= tg_score_s;
            k_r        <= {USER_W{1'b0}};
            cnt_r      <= {RANK_W{1'b0}};
            max_r      <= {SCORE_W{1'b0}};
            // A bad select skips the scan and completes on the next cycle.
            if (!q_ok_s) begin
              q_done_r     <= 1'b1;
              q_bad_r      <= 1'b1;
              rank_r       <= {RANK_W{1'b0}};
              user_score_r <= {SCORE_W{1'b0}};
              best_r       <= {SCORE_W{1'b0}};
            end
          end
        end
        SCAN: begin
          k_r   <= k_r + USER_W'(1);
          cnt_r <= cnt_next_s;
          max_r <= max_next_s;
          if (scan_last_s) begin
            q_done_r     <= 1'b1;
            q_bad_r      <= 1'b0;
            rank_r       <= cnt_next_s;
            user_score_r <= target_r;
            best_r       <= max_next_s;
          end else begin
            q_done_r <= 1'b0;
          end
        end
        DONE:    q_done_r <= 1'b0;
        default: q_done_r <= 1'b0;
      endcase
    end
  end

  assign upd_ready  = upd_ready_s;
  assign q_ready    = q_ready_s;
  assign q_done     = q_done_r;
  assign q_bad      = q_bad_r;
  assign rank       = rank_r;
  assign user_score = user_score_r;
  assign best_score = best_r;

endmodule

// File: tb/tb_score_rank_ctrl.sv
// Self-checking bench for score_rank_ctrl against a behavioural leaderboard
// model (array of scores, rank = count of strictly greater scores).
module tb_score_rank_ctrl;
  import score_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid, upd_ready;
  logic [2:0]  upd_song, upd_user;
  logic [9:0]  upd_score;
  logic        q_req, q_ready;
  logic [2:0]  q_song, q_user;
  logic        q_done, q_bad;
  logic [2:0]  rank;
  logic [9:0]  user_score, best_score;
  logic [79:0] scores_song0, scores_song1, scores_song2;

  int total = 0;
  int bad   = 0;
  logic [9:0] mdl [3][8];

  score_rank_ctrl dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_song(upd_song),
    .upd_user(upd_user), .upd_score(upd_score),
    .q_req(q_req), .q_ready(q_ready), .q_song(q_song), .q_user(q_user),
    .q_done(q_done), .q_bad(q_bad), .rank(rank),
    .user_score(user_score), .best_score(best_score),
    .scores_song0(scores_song0), .scores_song1(scores_song1),
    .scores_song2(scores_song2)
  );

  always #5 clk = ~clk;

  function automatic int oh_idx(input logic [2:0] sel);
    if (sel == 3'b001) return 0;
    else if (sel == 3'b010) return 1;
    else if (sel == 3'b100) return 2;
    else return -1;
  endfunction

  function automatic int ref_rank(input int s, input int u);
    int c = 0;
    for (int v = 0; v < 8; v++) if (mdl[s][v] > mdl[s][u]) c++;
    return c;
  endfunction

  function automatic int ref_best(input int s);
    int m = 0;
    for (int v = 0; v < 8; v++) if (int'(mdl[s][v]) > m) m = int'(mdl[s][v]);
    return m;
  endfunction

  function automatic logic [79:0] ref_flat(input int s);
    logic [79:0] f;
    for (int v = 0; v < 8; v++) f[v*10 +: 10] = mdl[s][v];
    return f;
  endfunction

  function automatic logic [79:0] dut_flat(input int s);
    if (s == 0) return scores_song0;
    else if (s == 1) return scores_song1;
    else return scores_song2;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) for (int v = 0; v < 8; v++) mdl[s][v] = 10'd0;
  endtask

  task automatic model_write(input logic [2:0] s, input int u, input int sc);
    int i;
    i = oh_idx(s);
    if (i >= 0) begin
`ifdef SCORE_KEEP_BEST_EN
      if (sc > int'(mdl[i][u])) mdl[i][u] = sc[9:0];
`else
      mdl[i][u] = sc[9:0];
`endif
    end
  endtask

  task automatic do_update(input logic [2:0] s, input int u, input int sc, output bit acc);
    acc = 1'b0;
    upd_song = s; upd_user = u[2:0]; upd_score = sc[9:0]; upd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (upd_ready) begin acc = 1'b1; break; end
    end
    if (acc) begin
      @(posedge clk);
      model_write(s, u, sc);
    end
    #1 upd_valid = 1'b0;
  endtask

  task automatic do_query(input logic [2:0] s, input int u, output bit done, output int lat,
                          output int r, output int us, output int bs, output bit qb);
    bit acc = 1'b0;
    done = 1'b0; lat = 0; r = 0; us = 0; bs = 0; qb = 1'b0;
    q_song = s; q_user = u[2:0]; q_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q_ready) begin acc = 1'b1; break; end
    end
    if (acc) @(posedge clk);
    #1 q_req = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (q_done) begin
          done = 1'b1; lat = i; r = int'(rank); us = int'(user_score);
          bs = int'(best_score); qb = q_bad;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    bit dn, qb; int lat, r, us, bs;
    @(negedge clk);
    total++; if (q_done !== 1'b0 || q_bad !== 1'b0) begin bad++; $display("FAIL reset_flags: got done=%b bad=%b expected 0 0", q_done, q_bad); end
    total++; if (rank !== 3'd0 || user_score !== 10'd0 || best_score !== 10'd0) begin bad++; $display("FAIL reset_results: got %0d %0d %0d expected 0 0 0", rank, user_score, best_score); end
    total++; if (upd_ready !== 1'b1 || q_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b %b expected 1 1", upd_ready, q_ready); end
    total++; if (scores_song0 !== 80'd0 || scores_song1 !== 80'd0 || scores_song2 !== 80'd0) begin bad++; $display("FAIL reset_table: got %h expected 0", scores_song0); end
    do_query(3'b001, 3, dn, lat, r, us, bs, qb);
    total++; if (!dn || lat != 9) begin bad++; $display("FAIL reset_query_latency: got done=%0d lat=%0d expected 1 9", dn, lat); end
    total++; if (r != 0 || us != 0 || bs != 0 || qb) begin bad++; $display("FAIL reset_query_result: got %0d %0d %0d %0d expected 0 0 0 0", r, us, bs, qb); end
  endtask

  task automatic test_ordered();
    bit acc, dn, qb; int lat, r, us, bs;
    for (int u = 0; u < 8; u++) do_update(3'b001, u, (u + 1) * 100, acc);
    @(negedge clk);
    total++; if (scores_song0 !== ref_flat(0)) begin bad++; $display("FAIL ordered_table: got %h expected %h", scores_song0, ref_flat(0)); end
    do_query(3'b001, 2, dn, lat, r, us, bs, qb);
    total++; if (!dn || lat != 9) begin bad++; $display("FAIL ordered_latency: got done=%0d lat=%0d expected 1 9", dn, lat); end
    total++; if (r != 5 || us != 300 || bs != 800 || qb) begin bad++; $display("FAIL ordered_result: got %0d %0d %0d expected 5 300 800", r, us, bs); end
  endtask

  task automatic test_ties();
    bit acc, dn, qb; int lat, r, us, bs;
    do_update(3'b010, 0, 500, acc);
    do_update(3'b010, 1, 500, acc);
    do_update(3'b010, 2, 400, acc);
    do_query(3'b010, 1, dn, lat, r, us, bs, qb);
    total++; if (!dn || r != 0 || us != 500 || bs != 500) begin bad++; $display("FAIL tie_user1: got %0d %0d %0d expected 0 500 500", r, us, bs); end
    do_query(3'b010, 2, dn, lat, r, us, bs, qb);
    total++; if (!dn || r != 2 || us != 400 || bs != 500) begin bad++; $display("FAIL tie_user2: got %0d %0d %0d expected 2 400 500", r, us, bs); end
  endtask

  task automatic test_arbitration();
    bit early = 1'b0, dn = 1'b0; int lat = 0, r = 0, us = 0, bs = 0;
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_song = 3'b001; upd_user = 3'd0; upd_score = 10'd900;
    q_req = 1'b1; q_song = 3'b001; q_user = 3'd0;
    @(negedge clk);
    total++; if (upd_ready !== 1'b1 || q_ready !== 1'b0) begin bad++; $display("FAIL arb_priority: got upd_ready=%b q_ready=%b expected 1 0", upd_ready, q_ready); end
    @(posedge clk); model_write(3'b001, 0, 900); #1 upd_valid = 1'b0;
    @(negedge clk);
    total++; if (q_ready !== 1'b1 || scores_song0 !== ref_flat(0)) begin bad++; $display("FAIL arb_second: got q_ready=%b table=%h expected 1 %h", q_ready, scores_song0, ref_flat(0)); end
    @(posedge clk); #1 q_req = 1'b0;
    upd_valid = 1'b1; upd_user = 3'd1; upd_score = 10'd111;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (upd_ready) early = 1'b1;
      if (q_done) begin dn = 1'b1; lat = i; r = int'(rank); us = int'(user_score); bs = int'(best_score); break; end
    end
    total++; if (!dn || lat != 9 || early) begin bad++; $display("FAIL arb_scan_block: got done=%0d lat=%0d early_ready=%0d expected 1 9 0", dn, lat, early); end
    total++; if (r != ref_rank(0, 0) || us != 900 || bs != ref_best(0)) begin bad++; $display("FAIL arb_result: got %0d %0d %0d expected %0d 900 %0d", r, us, bs, ref_rank(0, 0), ref_best(0)); end
    @(negedge clk);
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL arb_ready_after: got %b expected 1", upd_ready); end
    @(posedge clk); model_write(3'b001, 1, 111); #1 upd_valid = 1'b0;
    @(negedge clk);
    total++; if (scores_song0 !== ref_flat(0)) begin bad++; $display("FAIL arb_late_write: got %h expected %h", scores_song0, ref_flat(0)); end
  endtask

  task automatic test_bad_select();
    bit acc, dn, qb; int lat, r, us, bs;
    do_query(3'b011, 4, dn, lat, r, us, bs, qb);
    total++; if (!dn || lat != 1 || !qb) begin bad++; $display("FAIL bad_sel_path: got done=%0d lat=%0d bad=%0d expected 1 1 1", dn, lat, qb); end
    total++; if (r != 0 || us != 0 || bs != 0) begin bad++; $display("FAIL bad_sel_result: got %0d %0d %0d expected 0 0 0", r, us, bs); end
    do_update(3'b000, 2, 777, acc);
    @(negedge clk);
    total++; if (!acc || scores_song0 !== ref_flat(0) || scores_song1 !== ref_flat(1) || scores_song2 !== ref_flat(2)) begin bad++; $display("FAIL bad_sel_update: got acc=%0d s0=%h expected 1 %h", acc, scores_song0, ref_flat(0)); end
    do_query(3'b001, 0, dn, lat, r, us, bs, qb);
    total++; if (!dn || qb) begin bad++; $display("FAIL bad_sel_clear: got done=%0d bad=%0d expected 1 0", dn, qb); end
  endtask

  task automatic test_keep_best();
    bit acc; logic [79:0] f; int exp1;
`ifdef SCORE_KEEP_BEST_EN
    exp1 = 600;
`else
    exp1 = 400;
`endif
    do_update(3'b100, 5, 600, acc);
    do_update(3'b100, 5, 400, acc);
    @(negedge clk); f = scores_song2;
    total++; if (!acc || int'(f[59:50]) != exp1) begin bad++; $display("FAIL keep_best_lower: got %0d expected %0d", f[59:50], exp1); end
    do_update(3'b100, 5, 650, acc);
    @(negedge clk); f = scores_song2;
    total++; if (int'(f[59:50]) != 650 || f !== ref_flat(2)) begin bad++; $display("FAIL keep_best_higher: got %0d expected 650", f[59:50]); end
  endtask

  task automatic test_random();
    bit acc, dn, qb; int lat, r, us, bs, si, u, sc, er, eu, eb, el; logic [2:0] s;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       s = 3'b011;
        1:       s = 3'b000;
        2, 3:    s = 3'b001;
        4, 5:    s = 3'b010;
        default: s = 3'b100;
      endcase
      u = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) begin
        si = oh_idx(s);
        if (si >= 0) begin er = ref_rank(si, u); eu = int'(mdl[si][u]); eb = ref_best(si); el = 9; end
        else begin er = 0; eu = 0; eb = 0; el = 1; end
        do_query(s, u, dn, lat, r, us, bs, qb);
        total++;
        if (!dn || lat != el || r != er || us != eu || bs != eb || qb != (si < 0)) begin
          bad++;
          $display("FAIL rand_query %0d: got done=%0d lat=%0d r=%0d us=%0d bs=%0d bad=%0d expected lat=%0d r=%0d us=%0d bs=%0d", n, dn, lat, r, us, bs, qb, el, er, eu, eb);
        end
      end else begin
        sc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) * 64 : $urandom_range(0, 1023);
        do_update(s, u, sc, acc);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++; if (dut_flat(k) !== ref_flat(k)) begin bad++; $display("FAIL rand_table song%0d: got %h expected %h", k, dut_flat(k), ref_flat(k)); end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit acc = 1'b0, seen = 1'b0, dn, qb; int lat, r, us, bs;
    do_update(3'b001, 6, 321, acc);
    q_song = 3'b001; q_user = 3'd6; q_req = 1'b1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (q_ready) break; end
    @(posedge clk); #1 q_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (q_done !== 1'b0 || rank !== 3'd0 || user_score !== 10'd0 || best_score !== 10'd0 || q_bad !== 1'b0) begin bad++; $display("FAIL rst_scan_outputs: got %b %0d %0d %0d expected all 0", q_done, rank, user_score, best_score); end
    total++; if (scores_song0 !== 80'd0 || scores_song1 !== 80'd0 || scores_song2 !== 80'd0) begin bad++; $display("FAIL rst_scan_table: got %h expected 0", scores_song0); end
    model_clear();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (q_done) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL rst_scan_no_done: got q_done=1 expected 0"); end
    do_query(3'b001, 6, dn, lat, r, us, bs, qb);
    total++; if (!dn || lat != 9 || r != 0 || us != 0 || bs != 0) begin bad++; $display("FAIL rst_scan_requery: got done=%0d lat=%0d %0d %0d %0d expected 1 9 0 0 0", dn, lat, r, us, bs); end
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_song = 3'b000; upd_user = 3'd0; upd_score = 10'd0;
    q_req = 1'b0; q_song = 3'b000; q_user = 3'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_ordered();
    test_ties();
    test_arbitration();
    test_bad_select();
    test_keep_best();
    test_random();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
